// File: rtl/mem_dbus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_dbus_ctrl
//
// MEM-stage data-bus controller. Takes the instruction held in the EXE/MEM
// register, issues at most one load or store for it on a split addr/data
// handshake bus, holds the pipeline while the access is outstanding, and hands
// the aligned, sign/zero-extended load result to the MEM/WB register. It also
// reports address-error exceptions and drains an accepted access when a flush
// arrives, so that a response never lands on the wrong instruction.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   mem_memtype       one-hot op [7]LB [6]LBU [5]LH [4]LHU [3]LW [2]SB [1]SH [0]SW
//   mem_wd            effective address
//   mem_din           store data (low byte/half/word used)
//   mem_exe_exccode   exception code from earlier stages
//   flush             pipeline flush
//   dbus_req/wr/addr/wstrb/wdata   request side of the data bus
//   dbus_addr_ok      request accepted this cycle
//   dbus_data_ok      response this cycle; dbus_rdata valid with it
//   stall_req_mem     hold IF..EXE/MEM while the access is outstanding
//   load_data         aligned/extended load result (held between loads)
//   load_valid        one-cycle strobe with load_data
//   mem_exccode_o     merged exception code
//   badvaddr          faulting address on a misaligned access, else 0
// -----------------------------------------------------------------------------
module mem_dbus_ctrl #(
  parameter logic [4:0] EXC_NONE = 5'h10,
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_memtype,
  input  logic [31:0] mem_wd,
  input  logic [31:0] mem_din,
  input  logic [4:0]  mem_exe_exccode,
  input  logic        flush,
  output logic        dbus_req,
  output logic        dbus_wr,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata,
  output logic        stall_req_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic [4:0]  mem_exccode_o,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        flush_seen_q, flush_seen_d;

  // Request attributes latched when the access starts, so the bus sees stable
  // values for as long as the request is outstanding.
  logic [31:0] addr_q;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [3:0]  ld_q;       // {LB,LBU,LH,LHU}; all zero means LW
  logic [1:0]  off_q;
  logic        is_load_q;
  logic [31:0] load_data_q;

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------
  // st = {SB,SH,SW}
  function automatic logic [3:0] store_strb(input logic [2:0] st, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (st[2])      s = 4'b0001 << a;
    else if (st[1]) s = a[1] ? 4'b1100 : 4'b0011;
    else if (st[0]) s = 4'b1111;
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] st, input logic [31:0] din);
    logic [31:0] w;
    w = 32'h0;
    if (st[2])      w = {4{din[7:0]}};
    else if (st[1]) w = {2{din[15:0]}};
    else if (st[0]) w = din;
    return w;
  endfunction

  // ld = {LB,LBU,LH,LHU}; none set selects the full word.
  function automatic logic [31:0] load_extract(input logic [3:0]  ld,
                                               input logic [1:0]  a,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    if (ld[3])      r = {{24{b[7]}}, b};
    else if (ld[2]) r = {24'h0, b};
    else if (ld[1]) r = {{16{h[15]}}, h};
    else if (ld[0]) r = {16'h0, h};
    else            r = rdata;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Decode, alignment and exception merge
  // ---------------------------------------------------------------------------
  logic        is_load_c;
  logic        is_store_c;
  logic        need_half_c;
  logic        need_word_c;
  logic        misalign_c;
  logic        in_exc_c;
  logic        start;
  logic [31:0] addr_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;

  assign is_load_c   = |mem_memtype[7:3];
  assign is_store_c  = |mem_memtype[2:0];
  assign need_half_c = mem_memtype[5] | mem_memtype[4] | mem_memtype[1];
  assign need_word_c = mem_memtype[3] | mem_memtype[0];
  assign misalign_c  = (need_half_c & mem_wd[0]) | (need_word_c & (|mem_wd[1:0]));
  assign in_exc_c    = (mem_exe_exccode != EXC_NONE);

  assign addr_c  = {mem_wd[31:2], 2'b00};
  assign wstrb_c = store_strb(mem_memtype[2:0], mem_wd[1:0]);
  assign wdata_c = store_lanes(mem_memtype[2:0], mem_din);

  // An exception from an earlier stage outranks our own alignment check.
  always_comb begin
    mem_exccode_o = EXC_NONE;
    badvaddr      = 32'h0;
    if (in_exc_c) begin
      mem_exccode_o = mem_exe_exccode;
    end else if (misalign_c) begin
      mem_exccode_o = is_load_c ? EXC_ADEL : EXC_ADES;
      badvaddr      = mem_wd;
    end
  end

  assign start = (|mem_memtype) & ~in_exc_c & ~misalign_c & ~flush & (state_q == S_IDLE);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  // The start cycle already presents the request, so it follows the same
  // accept rules as S_REQ: a 0-wait slave can accept (and even answer) at once.
  logic        capture;
  logic [3:0]  cap_ld;
  logic [1:0]  cap_off;
  logic        cap_is_load;

  always_comb begin
    state_d      = state_q;
    flush_seen_d = flush_seen_q;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dbus_addr_ok && dbus_data_ok) begin
            state_d = S_DONE;
            capture = 1'b1;
          end else if (dbus_addr_ok) begin
            state_d      = S_WAIT;
            flush_seen_d = 1'b0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dbus_addr_ok && dbus_data_ok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            capture = 1'b1;
          end
        end else if (dbus_addr_ok) begin
          // Accepted in the same cycle as a flush: the response must still be drained.
          state_d      = S_WAIT;
          flush_seen_d = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dbus_data_ok) begin
          flush_seen_d = 1'b0;
          if (flush_seen_q || flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            capture = 1'b1;
          end
        end else if (flush) begin
          flush_seen_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        flush_seen_d = 1'b0;
      end
    endcase
  end

  // A capture straight out of S_IDLE happens before the attribute registers
  // have been loaded, so take the load type from the live inputs there.
  always_comb begin
    cap_ld      = ld_q;
    cap_off     = off_q;
    cap_is_load = is_load_q;
    if (state_q == S_IDLE) begin
      cap_ld      = mem_memtype[7:4];
      cap_off     = mem_wd[1:0];
      cap_is_load = is_load_c;
    end
  end

  // ---------------------------------------------------------------------------
  // State and attribute registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flush_seen_q <= 1'b0;
      addr_q       <= 32'h0;
      wr_q         <= 1'b0;
      wstrb_q      <= 4'h0;
      wdata_q      <= 32'h0;
      ld_q         <= 4'h0;
      off_q        <= 2'b00;
      is_load_q    <= 1'b0;
      load_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      flush_seen_q <= flush_seen_d;
      if (start) begin
        addr_q    <= addr_c;
        wr_q      <= is_store_c;
        wstrb_q   <= wstrb_c;
        wdata_q   <= wdata_c;
        ld_q      <= mem_memtype[7:4];
        off_q     <= mem_wd[1:0];
        is_load_q <= is_load_c;
      end
      if (capture && cap_is_load) begin
        load_data_q <= load_extract(cap_ld, cap_off, dbus_rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dbus_req      = start | (state_q == S_REQ);
  assign dbus_wr       = start ? is_store_c : wr_q;
  assign dbus_addr     = start ? addr_c     : addr_q;
  assign dbus_wstrb    = start ? wstrb_c    : wstrb_q;
  assign dbus_wdata    = start ? wdata_c    : wdata_q;

  // S_WAIT with flush_seen set keeps stalling until the orphaned response drains.
  assign stall_req_mem = start | (state_q == S_REQ) | (state_q == S_WAIT);
  assign load_valid    = (state_q == S_DONE) & is_load_q;
  assign load_data     = load_data_q;

endmodule
